comp2bit_checker: RTL

COMP2BIT_CHECKER -- requirements
Module: comp2bit_checker

---
 rtl/comp2bit_pkg.sv | 7 +
 rtl/comp2bit_ref.sv | 10 +
 rtl/comp2bit_checker.sv | 102 ++++++++++
 3 files changed

// File: rtl/comp2bit_pkg.sv
// comp2bit_pkg: shared FSM state type, vector count and index/count widths for the 2-bit comparator checker.
package comp2bit_pkg;
    localparam int NUM_VECTORS = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} stateT;
endpackage

// File: rtl/comp2bit_ref.sv
// comp2bit_ref: combinational golden model giving the expected one-hot {AgB,AeB,AlB} for a 2-bit operand pair.
module comp2bit_ref
    import comp2bit_pkg::*;
(
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic [2:0] expected
);
    assign expected = {A > B, A == B, A < B};
endmodule

// File: rtl/comp2bit_checker.sv
// comp2bit_checker: sweeps all 16 2-bit operand pairs through an external comparator and counts wrong responses.
// Define COMP2BIT_CHECKER_LOG_EN to add first-failure capture (first_fail_valid, first_fail_idx).
module comp2bit_checker
    import comp2bit_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [1:0]       A,
    output logic [1:0]       B,
    input  logic             AgB,
    input  logic             AeB,
    input  logic             AlB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] vec_idx
`ifdef COMP2BIT_CHECKER_LOG_EN
    ,
    output logic             first_fail_valid,
    output logic [IDX_W-1:0] first_fail_idx
`endif
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = CNT_W'(NUM_VECTORS);

    stateT      state;
    logic [3:0] settleCnt;
    logic [2:0] expected;
    logic       mismatch;

    comp2bit_ref goldRef (.A(A), .B(B), .expected(expected));

    // All-zero and multi-hot responses can never equal the one-hot golden value.
    assign mismatch = {AgB, AeB, AlB} != expected;
    assign busy = (state == SETTLE) || (state == SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            A <= '0;
            B <= '0;
            vec_idx <= '0;
            err_count <= '0;
            done <= 1'b0;
            pass <= 1'b0;
            settleCnt <= '0;
`ifdef COMP2BIT_CHECKER_LOG_EN
            first_fail_valid <= 1'b0;
            first_fail_idx <= '0;
`endif
        end else begin
            A <= vec_idx[1:0];
            B <= vec_idx[3:2];
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= SETTLE;
                        vec_idx <= '0;
                        err_count <= '0;
                        done <= 1'b0;
                        pass <= 1'b0;
                        settleCnt <= SETTLE_LOAD;
`ifdef COMP2BIT_CHECKER_LOG_EN
                        first_fail_valid <= 1'b0;
                        first_fail_idx <= '0;
`endif
                    end else if (state == DONE) begin
                        done <= 1'b1;
                        pass <= err_count == '0;
                    end
                end
                SETTLE: begin
                    settleCnt <= settleCnt - 1'b1;
                    state <= (settleCnt <= 4'd1) ? SAMPLE : SETTLE;
                end
                SAMPLE: begin
                    if (mismatch && err_count != ERR_MAX)
                        err_count <= err_count + 1'b1;
`ifdef COMP2BIT_CHECKER_LOG_EN
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx <= vec_idx;
                    end
`endif
                    if (vec_idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        vec_idx <= vec_idx + 1'b1;
                        settleCnt <= SETTLE_LOAD;
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
